// File: rtl/l80_io_pkg.sv
// rtl/l80_io_pkg.sv - register map, bit positions and drain FSM encoding for l80_uart_fifo_io
package l80_io_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [1:0] OFF_DATA  = 2'd0;
    localparam logic [1:0] OFF_STAT  = 2'd1;
    localparam logic [1:0] OFF_CTRL  = 2'd2;
    localparam logic [1:0] OFF_RXCNT = 2'd3;

    // STAT bit positions
    localparam int STAT_RX_AVAIL = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 4;
    localparam int STAT_TX_FULL  = 5;
    localparam int STAT_RX_OVR   = 6;
    localparam int STAT_TX_OVF   = 7;

    // CTRL bit positions
    localparam int CTRL_IE_RXAVAIL = 0;
    localparam int CTRL_IE_OVR     = 1;
    localparam int CTRL_IE_TXEMPTY = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WAITHI = 2'd2,
        ST_WAITLO = 2'd3
    } drain_state_t;

endpackage

// File: rtl/l80_sync_fifo.sv
// rtl/l80_sync_fifo.sv - single-clock FIFO with occupancy count
// Ports: clock, reset_n (async, active-low); push/din write side; pop/dout read side
// (dout shows the head, valid while !empty); full, empty, count status.
module l80_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so push while full is accepted then.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/l80_uart_fifo_io.sv
// rtl/l80_uart_fifo_io.sv - buffered UART I/O-space peripheral for the light8080 SoC
// Ports: clock, reset_n (async, active-low); CPU bus cpu_addr/cpu_io/cpu_rd/cpu_wr/cpu_dout
// with registered read data io_dout; UART core side tx_valid/tx_data/tx_busy and
// rx_data/rx_valid; irq level interrupt request.
module l80_uart_fifo_io
    import l80_io_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h80,
    parameter int         RX_DEPTH  = 16,
    parameter int         TX_DEPTH  = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] cpu_addr,
    input  logic       cpu_io,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_dout,
    output logic [7:0] io_dout,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       irq
);

    localparam int RXW = $clog2(RX_DEPTH) + 1;
    localparam int TXW = $clog2(TX_DEPTH) + 1;

    logic [7:0]     addr_off;
    logic           in_range;
    logic           sel_data, sel_stat, sel_ctrl;
    logic           rd_q, wr_q;
    logic           rd_first, wr_first;

    logic           rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]     rx_head;
    logic [RXW-1:0] rx_count;
    logic           tx_push, tx_pop, tx_wr, tx_full, tx_empty;
    logic [7:0]     tx_head;
    logic [TXW-1:0] tx_count_unused;

    logic           rx_ovr, tx_ovf;
    logic           rx_ovr_set, tx_ovf_set, stat_clr;
    logic [2:0]     ctrl;
    logic [7:0]     stat;
    logic [8:0]     rx_count_w;
    logic [7:0]     rxcnt_byte;
    logic [7:0]     rd_mux;
    drain_state_t   state;

    // Offset arithmetic keeps the decode correct even if the block wraps past 8'hFF.
    assign addr_off = cpu_addr - BASE_ADDR;
    assign in_range = cpu_io & (addr_off < 8'd4);
    assign sel_data = in_range & (addr_off[1:0] == OFF_DATA);
    assign sel_stat = in_range & (addr_off[1:0] == OFF_STAT);
    assign sel_ctrl = in_range & (addr_off[1:0] == OFF_CTRL);

    // Strobes may be held for several cycles; side effects key off the rising edge only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            rd_q <= cpu_rd;
            wr_q <= cpu_wr;
        end
    end
    assign rd_first = cpu_rd & ~rd_q;
    assign wr_first = cpu_wr & ~wr_q;

    assign rx_pop     = sel_data & rd_first & ~rx_empty;
    assign rx_push    = rx_valid & (~rx_full | rx_pop);
    assign rx_ovr_set = rx_valid & rx_full & ~rx_pop;

    assign tx_pop     = (state == ST_LOAD);
    assign tx_wr      = sel_data & wr_first;
    assign tx_push    = tx_wr & (~tx_full | tx_pop);
    assign tx_ovf_set = tx_wr & tx_full & ~tx_pop;

    assign stat_clr   = sel_stat & rd_first;

    l80_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (rx_push),
        .pop     (rx_pop),
        .din     (rx_data),
        .dout    (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    l80_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (tx_push),
        .pop     (tx_pop),
        .din     (cpu_dout),
        .dout    (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count_unused)
    );

    // Sticky flags: a new overrun in the clearing cycle wins over the clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_ovr <= 1'b0;
            tx_ovf <= 1'b0;
            ctrl   <= 3'b000;
        end else begin
            rx_ovr <= rx_ovr_set | (rx_ovr & ~stat_clr);
            tx_ovf <= tx_ovf_set | (tx_ovf & ~stat_clr);
            if (sel_ctrl && wr_first) begin
                ctrl <= cpu_dout[2:0];
            end
        end
    end

    // RXCNT is a byte; only a 256-deep FIFO can exceed it.
    assign rx_count_w = 9'(rx_count);
    assign rxcnt_byte = rx_count_w[8] ? 8'hFF : rx_count_w[7:0];

    always_comb begin
        stat                = 8'h00;
        stat[STAT_RX_AVAIL] = ~rx_empty;
        stat[STAT_RX_FULL]  = rx_full;
        stat[STAT_TX_EMPTY] = tx_empty;
        stat[STAT_TX_FULL]  = tx_full;
        stat[STAT_RX_OVR]   = rx_ovr;
        stat[STAT_TX_OVF]   = tx_ovf;
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr_off[1:0])
            OFF_DATA: rd_mux = rx_head;
            OFF_STAT: rd_mux = stat;
            OFF_CTRL: rd_mux = {5'b00000, ctrl};
            default:  rd_mux = rxcnt_byte;
        endcase
    end

    // DATA captures the head before this edge's pop takes effect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            io_dout <= 8'h00;
        end else if (in_range) begin
            io_dout <= rd_mux;
        end
    end

    // Drain FSM: tx_valid is high exactly for the LOAD cycle, and the head is
    // popped at the end of LOAD, so tx_data is stable during the pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!tx_empty && !tx_busy) begin
                        state    <= ST_LOAD;
                        tx_valid <= 1'b1;
                        tx_data  <= tx_head;
                    end
                end
                ST_LOAD:   state <= ST_WAITHI;
                ST_WAITHI: if (tx_busy)  state <= ST_WAITLO;
                ST_WAITLO: if (!tx_busy) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign irq = (ctrl[CTRL_IE_RXAVAIL] & ~rx_empty)
               | (ctrl[CTRL_IE_OVR] & (rx_ovr | tx_ovf))
               | (ctrl[CTRL_IE_TXEMPTY] & tx_empty & (state == ST_IDLE));

endmodule

// File: tb/tb_l80_uart_fifo_io.sv
// tb/tb_l80_uart_fifo_io.sv - randomized self-checking bench for l80_uart_fifo_io
module tb_l80_uart_fifo_io;

    localparam logic [7:0] BASE = 8'h80;
    localparam int RXD = 4;
    localparam int TXD = 4;
    localparam logic [1:0] R_DATA = 2'd0, R_STAT = 2'd1, R_CTRL = 2'd2, R_RXCNT = 2'd3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] cpu_addr, cpu_dout, rx_data;
    logic       cpu_io, cpu_rd, cpu_wr, rx_valid;
    logic [7:0] io_dout, tx_data;
    logic       tx_valid, irq, tx_busy;

    logic       busy_force, uart_busy, uart_en;
    int         busy_cnt;
    logic [7:0] tx_seen[$];
    logic [7:0] tx_sent[$];
    logic [7:0] rx_q[$];
    logic       ovr_m;
    logic [2:0] ctrl_m;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clock = ~clock;

    assign tx_busy = busy_force | uart_busy;

    l80_uart_fifo_io #(.BASE_ADDR(BASE), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cpu_addr (cpu_addr),
        .cpu_io   (cpu_io),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_dout (cpu_dout),
        .io_dout  (io_dout),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .irq      (irq)
    );

    // UART core model: logs every tx_valid pulse and stays busy for 10 cycles.
    always @(negedge clock) begin
        if (!reset_n) begin
            uart_busy = 1'b0;
            busy_cnt  = 0;
        end else if (tx_valid) begin
            tx_seen.push_back(tx_data);
            if (uart_en) begin
                uart_busy = 1'b1;
                busy_cnt  = 10;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) uart_busy = 1'b0;
        end
    end

    task automatic bus_read(input logic [1:0] off, input int hold, output logic [7:0] d);
        @(negedge clock);
        cpu_addr = BASE + 8'(off);
        cpu_io = 1'b1;
        cpu_rd = 1'b1;
        @(negedge clock);
        d = io_dout;
        repeat (hold - 1) @(negedge clock);
        cpu_rd = 1'b0;
        cpu_io = 1'b0;
        @(negedge clock);
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [7:0] v, input int hold);
        @(negedge clock);
        cpu_addr = BASE + 8'(off);
        cpu_dout = v;
        cpu_io = 1'b1;
        cpu_wr = 1'b1;
        repeat (hold) @(negedge clock);
        cpu_wr = 1'b0;
        cpu_io = 1'b0;
        @(negedge clock);
    endtask

    task automatic rx_pulse(input logic [7:0] v);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data = v;
        @(negedge clock);
        rx_valid = 1'b0;
        if (rx_q.size() < RXD) rx_q.push_back(v);
        else ovr_m = 1'b1;
    endtask

    task automatic wait_tx(input int n);
        int t = 0;
        while (tx_seen.size() < n && t < 1000) begin
            @(negedge clock);
            t++;
        end
        repeat (30) @(negedge clock);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_vec++; if (io_dout !== 8'h00) begin n_err++; $display("FAIL reset_io_dout got %h want 00", io_dout); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        bus_read(R_STAT, 1, d);
        n_vec++; if (d !== 8'h10) begin n_err++; $display("FAIL reset_stat got %h want 10", d); end
        repeat (10) @(negedge clock);
        n_vec++; if (tx_seen.size() != 0) begin n_err++; $display("FAIL reset_no_tx got %0d pulses want 0", tx_seen.size()); end
    endtask

    task automatic test_tx_pair();
        tx_seen.delete();
        @(negedge clock);
        cpu_addr = BASE; cpu_dout = 8'h41; cpu_io = 1'b1; cpu_wr = 1'b1;
        @(negedge clock);
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_latency1 got %b want 0", tx_valid); end
        @(negedge clock);
        n_vec++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL tx_latency2 got %b want 1", tx_valid); end
        n_vec++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL tx_data_first got %h want 41", tx_data); end
        @(negedge clock);
        cpu_wr = 1'b0; cpu_io = 1'b0;
        @(negedge clock);
        bus_write(R_DATA, 8'h42, 3);
        wait_tx(2);
        n_vec++; if (tx_seen.size() != 2) begin n_err++; $display("FAIL tx_pair_count got %0d want 2", tx_seen.size()); end
        if (tx_seen.size() == 2) begin
            n_vec++; if (tx_seen[0] !== 8'h41 || tx_seen[1] !== 8'h42) begin
                n_err++; $display("FAIL tx_pair_data got %h %h want 41 42", tx_seen[0], tx_seen[1]);
            end
        end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] d;
        for (int i = 1; i <= 5; i++) rx_pulse(8'(i));
        bus_read(R_STAT, 1, d);
        n_vec++; if (d !== {1'b0, ovr_m, 2'b01, 2'b00, rx_q.size() == RXD, rx_q.size() != 0}) begin
            n_err++; $display("FAIL ovr_stat got %h want 53", d);
        end
        ovr_m = 1'b0;
        bus_read(R_RXCNT, 1, d);
        n_vec++; if (d !== 8'd4) begin n_err++; $display("FAIL ovr_rxcnt got %0d want 4", d); end
        for (int i = 0; i < 4; i++) begin
            bus_read(R_DATA, 2, d);
            n_vec++; if (d !== rx_q[0]) begin n_err++; $display("FAIL ovr_data%0d got %h want %h", i, d, rx_q[0]); end
            void'(rx_q.pop_front());
        end
        bus_read(R_STAT, 1, d);
        n_vec++; if (d !== 8'h10) begin n_err++; $display("FAIL ovr_cleared got %h want 10", d); end
    endtask

    task automatic test_pop_push_full();
        logic [7:0] d, nb;
        for (int i = 0; i < RXD; i++) rx_pulse(8'($urandom_range(0, 255)));
        nb = 8'($urandom_range(0, 255));
        @(negedge clock);
        cpu_addr = BASE; cpu_io = 1'b1; cpu_rd = 1'b1; rx_valid = 1'b1; rx_data = nb;
        @(negedge clock);
        d = io_dout;
        rx_valid = 1'b0; cpu_rd = 1'b0; cpu_io = 1'b0;
        n_vec++; if (d !== rx_q[0]) begin n_err++; $display("FAIL popush_head got %h want %h", d, rx_q[0]); end
        void'(rx_q.pop_front());
        rx_q.push_back(nb);
        @(negedge clock);
        bus_read(R_RXCNT, 1, d);
        n_vec++; if (d !== 8'd4) begin n_err++; $display("FAIL popush_rxcnt got %0d want 4", d); end
        bus_read(R_STAT, 1, d);
        n_vec++; if (d !== 8'h13) begin n_err++; $display("FAIL popush_stat got %h want 13", d); end
        while (rx_q.size() > 0) begin
            bus_read(R_DATA, 1, d);
            n_vec++; if (d !== rx_q[0]) begin n_err++; $display("FAIL popush_drain got %h want %h", d, rx_q[0]); end
            void'(rx_q.pop_front());
        end
    endtask

    task automatic test_irq();
        logic [7:0] d, b;
        bus_write(R_CTRL, 8'h01, 1);
        bus_read(R_CTRL, 1, d);
        n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL ctrl_readback got %h want 01", d); end
        b = 8'($urandom_range(0, 255));
        @(negedge clock);
        rx_valid = 1'b1; rx_data = b;
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_before got %b want 0", irq); end
        @(negedge clock);
        rx_valid = 1'b0;
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise got %b want 1", irq); end
        @(negedge clock);
        cpu_addr = BASE; cpu_io = 1'b1; cpu_rd = 1'b1;
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_hold got %b want 1", irq); end
        @(negedge clock);
        d = io_dout;
        cpu_rd = 1'b0; cpu_io = 1'b0;
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_fall got %b want 0", irq); end
        n_vec++; if (d !== b) begin n_err++; $display("FAIL irq_data got %h want %h", d, b); end
        bus_write(R_CTRL, 8'h00, 1);
    endtask

    task automatic test_tx_overflow();
        logic [7:0] d;
        tx_seen.delete();
        tx_sent.delete();
        busy_force = 1'b1;
        for (int i = 0; i < TXD + 1; i++) begin
            d = 8'($urandom_range(0, 255));
            if (i < TXD) tx_sent.push_back(d);
            bus_write(R_DATA, d, 1);
        end
        bus_read(R_STAT, 1, d);
        n_vec++; if (d !== 8'hA0) begin n_err++; $display("FAIL txovf_stat got %h want a0", d); end
        bus_read(R_STAT, 1, d);
        n_vec++; if (d !== 8'h20) begin n_err++; $display("FAIL txovf_clear got %h want 20", d); end
        busy_force = 1'b0;
        wait_tx(TXD);
        n_vec++; if (tx_seen.size() != TXD) begin n_err++; $display("FAIL txovf_count got %0d want %0d", tx_seen.size(), TXD); end
        for (int i = 0; i < TXD && i < tx_seen.size(); i++) begin
            n_vec++; if (tx_seen[i] !== tx_sent[i]) begin n_err++; $display("FAIL txovf_byte%0d got %h want %h", i, tx_seen[i], tx_sent[i]); end
        end
        bus_read(R_STAT, 1, d);
        n_vec++; if (d !== 8'h10) begin n_err++; $display("FAIL txovf_final got %h want 10", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        uart_en = 1'b0;
        tx_seen.delete();
        for (int i = 0; i < 4; i++) bus_write(R_DATA, 8'($urandom_range(0, 255)), 1);
        n_vec++; if (tx_seen.size() != 1) begin n_err++; $display("FAIL mid_one_sent got %0d want 1", tx_seen.size()); end
        bus_write(R_CTRL, 8'h04, 1);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_irq_busy got %b want 0", irq); end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_vec++; if (tx_valid !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL mid_reset got tx_valid=%b irq=%b want 0 0", tx_valid, irq); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        rx_q.delete();
        ovr_m = 1'b0;
        @(negedge clock);
        n_vec++; if (io_dout !== 8'h00) begin n_err++; $display("FAIL mid_io_dout got %h want 00", io_dout); end
        bus_read(R_STAT, 1, d);
        n_vec++; if (d !== 8'h10) begin n_err++; $display("FAIL mid_stat got %h want 10", d); end
        bus_write(R_CTRL, 8'h04, 1);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL mid_idle_irq got %b want 1", irq); end
        repeat (20) @(negedge clock);
        n_vec++; if (tx_seen.size() != 1) begin n_err++; $display("FAIL mid_no_resend got %0d want 1", tx_seen.size()); end
        uart_en = 1'b1;
        bus_write(R_CTRL, 8'h00, 1);
    endtask

    task automatic test_random();
        logic [7:0] d, exp;
        logic       irq_exp;
        int         op;
        tx_seen.delete();
        tx_sent.delete();
        ctrl_m = 3'b000;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 6);
            if (op == 4 && (tx_sent.size() - tx_seen.size()) >= TXD) op = 0;
            if (op == 1 && rx_q.size() == 0) op = 0;
            case (op)
                0: rx_pulse(8'($urandom_range(0, 255)));
                1: begin
                    bus_read(R_DATA, $urandom_range(1, 3), d);
                    n_vec++; if (d !== rx_q[0]) begin n_err++; $display("FAIL rnd_data got %h want %h", d, rx_q[0]); end
                    void'(rx_q.pop_front());
                end
                2: begin
                    bus_read(R_STAT, $urandom_range(1, 3), d);
                    exp = {1'b0, ovr_m, 4'b0000, rx_q.size() == RXD, rx_q.size() != 0};
                    n_vec++; if ((d & 8'hC3) !== exp) begin n_err++; $display("FAIL rnd_stat got %h want %h", d & 8'hC3, exp); end
                    ovr_m = 1'b0;
                end
                3: begin
                    bus_read(R_RXCNT, $urandom_range(1, 3), d);
                    n_vec++; if (d !== 8'(rx_q.size())) begin n_err++; $display("FAIL rnd_rxcnt got %0d want %0d", d, rx_q.size()); end
                end
                4: begin
                    d = 8'($urandom_range(0, 255));
                    tx_sent.push_back(d);
                    bus_write(R_DATA, d, $urandom_range(1, 3));
                end
                5: begin
                    ctrl_m = 3'($urandom_range(0, 3));
                    bus_write(R_CTRL, {5'b00000, ctrl_m}, $urandom_range(1, 3));
                end
                default: begin
                    @(negedge clock);
                    irq_exp = (ctrl_m[0] & (rx_q.size() != 0)) | (ctrl_m[1] & ovr_m);
                    n_vec++; if (irq !== irq_exp) begin n_err++; $display("FAIL rnd_irq got %b want %b", irq, irq_exp); end
                end
            endcase
        end
        wait_tx(tx_sent.size());
        n_vec++; if (tx_seen.size() != tx_sent.size()) begin
            n_err++; $display("FAIL rnd_tx_count got %0d want %0d", tx_seen.size(), tx_sent.size());
        end
        for (int i = 0; i < tx_sent.size() && i < tx_seen.size(); i++) begin
            n_vec++; if (tx_seen[i] !== tx_sent[i]) begin n_err++; $display("FAIL rnd_tx_byte%0d got %h want %h", i, tx_seen[i], tx_sent[i]); end
        end
        while (rx_q.size() > 0) begin
            bus_read(R_DATA, 1, d);
            n_vec++; if (d !== rx_q[0]) begin n_err++; $display("FAIL rnd_drain got %h want %h", d, rx_q[0]); end
            void'(rx_q.pop_front());
        end
        bus_write(R_CTRL, 8'h00, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_addr = 8'h00; cpu_dout = 8'h00; cpu_io = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00;
        busy_force = 1'b0; uart_busy = 1'b0; uart_en = 1'b1; busy_cnt = 0;
        ovr_m = 1'b0; ctrl_m = 3'b000;
        test_reset();
        test_tx_pair();
        test_rx_overrun();
        test_pop_push_full();
        test_irq();
        test_tx_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d vectors", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
